branch_resolution_unit: RTL
===========================

Name: branch_resolution_unit

Overview:
Execute-stage counterpart of the fetch-stage dynamic branch predictor. Resolves the real outcome of each conditional branch, JAL and JALR, and compares it with the prediction carried down the pipeline. On a mispredict it generates the fetch redirect and the IF/ID flush window. It also drives the registered training interface (actual taken/target) back to the predictor and keeps saturating branch and mispredict counters.

Parameters:
DATA_WIDTH, 32, width of PC, immediates and register operands
FLUSH_CYCLES, 2, number of cycles flush_fd is held after a redirect (1..15)
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
valid_e  input  1  execute-stage instruction valid
stall_e  input  1  execute stage stalled; instruction is not resolved this cycle
opcode_e  input  7  instruction bits [6:0]
funct3_e  input  3  instruction bits [14:12]
pc_e  input  DATA_WIDTH  PC of execute-stage instruction
imm_e  input  DATA_WIDTH  sign-extended B/J/I immediate
rs1_data_e  input  DATA_WIDTH  forwarded rs1 value
rs2_data_e  input  DATA_WIDTH  forwarded rs2 value
pred_taken_e  input  1  prediction carried from fetch
pred_target_e  input  DATA_WIDTH  predicted target carried from fetch
redirect  output  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  output  DATA_WIDTH  corrected fetch PC
flush_fd  output  1  squash IF/ID contents
upd_valid  output  1  one-cycle predictor training strobe
upd_pc  output  DATA_WIDTH  PC of resolved control-flow instruction
upd_taken  output  1  actual outcome
upd_target  output  DATA_WIDTH  actual taken target
upd_is_jump  output  1  1 = JAL (unconditional)
branch_count  output  CNT_WIDTH  resolved branches + JAL + JALR
mispredict_count  output  CNT_WIDTH  mispredicts

Behaviour:
- Reset: all outputs 0, state RUN, flush counter 0.
- Resolution happens only when state==RUN, valid_e=1 and stall_e=0.
- Branch (1100011): funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed), 110 BLTU, 111 BGEU (unsigned). funct3 010/011 counts as not-control-flow: no update, no count, no redirect. Target = pc_e + imm_e.
- JAL (1101111): always taken, target = pc_e + imm_e, upd_is_jump=1.
- JALR (1100111): always taken, target = (rs1_data_e + imm_e) & ~1. Counted and may redirect, but upd_valid=0 because the predictor only learns branch/JAL.
- All additions wrap modulo 2^DATA_WIDTH. Fall-through = pc_e + 4.
- Mispredict when actual_taken != pred_taken_e, or both are taken and pred_target_e != actual target.
- Correct PC = actual_taken ? target : pc_e + 4.
- Latency: resolution in cycle T; at T+1 the registered outputs appear:
  - redirect=1 (mispredict only) with redirect_pc;
  - upd_* for branch/JAL, correct or not;
  - counters incremented.
- Counters saturate at all-ones and never wrap.
- FSM RUN/FLUSH on mispredict: at T+1 state=FLUSH, flush_fd=1, counter loaded with FLUSH_CYCLES-1. flush_fd stays high while in FLUSH.
  - Each cycle in FLUSH the counter decrements; at 0 the FSM returns to RUN. flush_fd is therefore high exactly FLUSH_CYCLES cycles (T+1..T+FLUSH_CYCLES).
  - The counter decrements regardless of stall_e.
  - Instructions presented while in FLUSH are wrong-path: not resolved, not counted, no update, no redirect.
- redirect and upd_valid are single-cycle pulses; they fall at T+2 unless a new resolution occurs.
- Back-to-back correctly predicted branches resolve every cycle with no bubble.
- A stall during RUN holds nothing internal; the instruction resolves in the first unstalled cycle.
- Reset asserted mid-FLUSH: immediately returns to RUN, all outputs 0, counters cleared.

Decomposition:
- Shared package bru_pkg:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR;
  - funct3 constants F3_BEQ..F3_BGEU;
  - state enum {RUN, FLUSH}.
- One natural combinational sub-module, branch_comparator (rs1, rs2, funct3 -> taken, valid_f3).

Test Plan:
- BEQ at pc_e=0x100, imm=0x20, rs1=rs2=5, pred_taken=1, pred_target=0x120 -> no redirect; T+1 upd_valid=1, upd_taken=1, upd_target=0x120; branch_count=1, mispredict_count=0.
- BLT at pc_e=0x200, rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> taken (signed); T+1 redirect=1, redirect_pc=0x200+imm; flush_fd high 2 cycles; mispredict_count=1.
- BLTU with the same operands and pred_taken=1, pred_target=0x240 -> not taken; redirect_pc=0x204; valid branch presented during FLUSH is ignored (branch_count unchanged).
- JALR with rs1=0x1001, imm=4, pred_taken=1, pred_target=0x1004 -> target 0x1004, no redirect, upd_valid=0, branch_count+1.
- JAL at 0x300, pred_taken=0 while stall_e=1 for 2 cycles -> no activity during the stall; resolves on the first unstalled cycle with redirect_pc=0x300+imm and upd_is_jump=1.
- Force mispredict, assert rst at T+2 -> flush_fd, redirect and counters all 0 immediately; a correct branch after reset resolves normally.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared constants and types for the execute-stage branch resolution unit.
package bru_pkg;

    // Control-flow opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Conditional branch funct3 encodings (instruction bits [14:12])
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // RUN resolves instructions; FLUSH squashes the wrong path after a redirect
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

endpackage

// File: rtl/branch_comparator.sv
// Conditional-branch condition evaluator: decides taken and flags funct3 codes
// that are not real branches (010/011).
module branch_comparator
    import bru_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [2:0]            funct3_i,
    output logic                  taken_o,
    output logic                  valid_f3_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_i == rs2_i);
    assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u = (rs1_i < rs2_i);

    // Select the condition named by funct3
    always_comb begin
        taken_o    = 1'b0;
        valid_f3_o = 1'b1;
        unique case (funct3_i)
            F3_BEQ:  taken_o = eq;
            F3_BNE:  taken_o = ~eq;
            F3_BLT:  taken_o = lt_s;
            F3_BGE:  taken_o = ~lt_s;
            F3_BLTU: taken_o = lt_u;
            F3_BGEU: taken_o = ~lt_u;
            default: valid_f3_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Execute-stage branch resolution: computes the real outcome of branches, JAL
// and JALR, detects mispredicts, drives the fetch redirect / IF-ID flush window,
// trains the predictor and keeps saturating performance counters.
module branch_resolution_unit
    import bru_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_e,
    input  logic                  stall_e,
    input  logic [6:0]            opcode_e,
    input  logic [2:0]            funct3_e,
    input  logic [DATA_WIDTH-1:0] pc_e,
    input  logic [DATA_WIDTH-1:0] imm_e,
    input  logic [DATA_WIDTH-1:0] rs1_data_e,
    input  logic [DATA_WIDTH-1:0] rs2_data_e,
    input  logic                  pred_taken_e,
    input  logic [DATA_WIDTH-1:0] pred_target_e,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush_fd,
    output logic                  upd_valid,
    output logic [DATA_WIDTH-1:0] upd_pc,
    output logic                  upd_taken,
    output logic [DATA_WIDTH-1:0] upd_target,
    output logic                  upd_is_jump,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ClearLsb = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

    bru_state_e state_q;
    logic [3:0] flush_cnt_q;
    logic       flush_q;

    logic                  redirect_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;
    logic                  upd_valid_q;
    logic [DATA_WIDTH-1:0] upd_pc_q;
    logic                  upd_taken_q;
    logic [DATA_WIDTH-1:0] upd_target_q;
    logic                  upd_is_jump_q;
    logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;

    logic                  cmp_taken;
    logic                  cmp_valid_f3;
    logic                  is_branch;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  is_cf;
    logic                  resolve;
    logic                  actual_taken;
    logic [DATA_WIDTH-1:0] actual_target;
    logic [DATA_WIDTH-1:0] correct_pc;
    logic                  mispredict;
    logic                  do_redirect;
    logic                  do_update;

    branch_comparator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .rs1_i      (rs1_data_e),
        .rs2_i      (rs2_data_e),
        .funct3_i   (funct3_e),
        .taken_o    (cmp_taken),
        .valid_f3_o (cmp_valid_f3)
    );

    // Decode, outcome, target and mispredict detection for the current instruction
    always_comb begin
        is_branch     = (opcode_e == OP_BRANCH) && cmp_valid_f3;
        is_jal        = (opcode_e == OP_JAL);
        is_jalr       = (opcode_e == OP_JALR);
        is_cf         = is_branch || is_jal || is_jalr;
        resolve       = (state_q == RUN) && valid_e && !stall_e && is_cf;
        actual_taken  = is_branch ? cmp_taken : 1'b1;
        actual_target = is_jalr ? ((rs1_data_e + imm_e) & ClearLsb) : (pc_e + imm_e);
        correct_pc    = actual_taken ? actual_target : (pc_e + DATA_WIDTH'(4));
        // A matching taken prediction still mispredicts if it points elsewhere
        mispredict    = (actual_taken != pred_taken_e) ||
                        (actual_taken && (pred_target_e != actual_target));
        do_redirect   = resolve && mispredict;
        // JALR targets are register-dependent, so the predictor is not trained on them
        do_update     = resolve && !is_jalr;
    end

    // Saturating counter next-state
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (resolve && (branch_count_q != '1)) begin
            branch_count_d = branch_count_q + CNT_WIDTH'(1);
        end
        if (do_redirect && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
        end
    end

    // RUN/FLUSH FSM with registered flush_fd; the down-counter ignores stall_e
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
            flush_q     <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (do_redirect) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= FlushLoad;
                        flush_q     <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == 4'd0) begin
                        state_q <= RUN;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q     <= RUN;
                    flush_cnt_q <= 4'd0;
                    flush_q     <= 1'b0;
                end
            endcase
        end
    end

    // Registered redirect, predictor training and counters (visible one cycle after resolve)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q         <= 1'b0;
            redirect_pc_q      <= '0;
            upd_valid_q        <= 1'b0;
            upd_pc_q           <= '0;
            upd_taken_q        <= 1'b0;
            upd_target_q       <= '0;
            upd_is_jump_q      <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            redirect_q         <= do_redirect;
            upd_valid_q        <= do_update;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            if (do_redirect) begin
                redirect_pc_q <= correct_pc;
            end
            if (do_update) begin
                upd_pc_q      <= pc_e;
                upd_taken_q   <= actual_taken;
                upd_target_q  <= actual_target;
                upd_is_jump_q <= is_jal;
            end
        end
    end

    assign redirect         = redirect_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush_fd         = flush_q;
    assign upd_valid        = upd_valid_q;
    assign upd_pc           = upd_pc_q;
    assign upd_taken        = upd_taken_q;
    assign upd_target       = upd_target_q;
    assign upd_is_jump      = upd_is_jump_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
